// File: rtl/if_stage.sv
// Instruction-fetch stage: next-PC generation, 1-cycle instruction SRAM, IF register and ID handshake.
// Optional fetch-address-error check enabled by defining IF_ADEF_CHECK_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [32:0] BR_BUS,
  input  logic        ID_allow_in,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  output logic        IF_ready_go,
  output logic        IFreg_valid,
  output logic [31:0] IFreg_pc,
  output logic [31:0] IFreg_inst,
  output logic        IFreg_adef
);

  logic [31:0] r_fs_pc;
  logic        r_fs_valid;
  logic        r_br_pend;
  logic [31:0] r_br_tgt;
  logic [31:0] r_ibuf;
  logic        r_ibuf_vld;

  logic        w_br_taken;
  logic [31:0] w_br_target;
  logic        w_fs_allow_in;
  logic [31:0] w_nextpc;
  logic [31:0] w_fetch_inst;

  assign w_br_taken  = BR_BUS[0];
  assign w_br_target = BR_BUS[32:1];

  // SRAM answers in one cycle, so the IF register is always complete.
  assign IF_ready_go   = 1'b1;
  assign w_fs_allow_in = ~r_fs_valid | (IF_ready_go & ID_allow_in);

  // A live branch beats a deferred one so the newest redirect is never lost.
  assign w_nextpc = w_br_taken ? w_br_target :
                    r_br_pend  ? r_br_tgt    :
                                 r_fs_pc + 32'd4;

  assign inst_sram_we    = 4'b0000;
  assign inst_sram_wdata = 32'b0;
  assign inst_sram_addr  = w_nextpc;

  assign w_fetch_inst = r_ibuf_vld ? r_ibuf : inst_sram_rdata;
  assign IFreg_pc     = r_fs_pc;
  assign IFreg_valid  = r_fs_valid & ~w_br_taken & ~r_br_pend;

`ifdef IF_ADEF_CHECK_EN
  logic r_fs_adef;
  logic w_adef_err;

  assign w_adef_err   = |w_nextpc[1:0];
  assign inst_sram_en = ~reset & w_fs_allow_in & ~w_adef_err;
  assign IFreg_inst   = r_fs_adef ? 32'b0 : w_fetch_inst;
  assign IFreg_adef   = r_fs_adef;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fs_adef <= 1'b0;
    end else if (w_fs_allow_in) begin
      r_fs_adef <= w_adef_err;
    end
  end
`else
  assign inst_sram_en = ~reset & w_fs_allow_in;
  assign IFreg_inst   = w_fetch_inst;
  assign IFreg_adef   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fs_pc    <= RESET_PC - 32'd4;
      r_fs_valid <= 1'b0;
      r_br_pend  <= 1'b0;
      r_br_tgt   <= 32'b0;
      r_ibuf_vld <= 1'b0;
    end else if (w_fs_allow_in) begin
      r_fs_pc    <= w_nextpc;
      r_fs_valid <= 1'b1;
      r_br_pend  <= 1'b0;
      r_ibuf_vld <= 1'b0;
    end else begin
      if (w_br_taken) begin
        r_br_pend <= 1'b1;
        r_br_tgt  <= w_br_target;
      end
      // SRAM output is only trustworthy the cycle after a request; capture it once.
      if (r_fs_valid & ~ID_allow_in & ~r_ibuf_vld) begin
        r_ibuf     <= inst_sram_rdata;
        r_ibuf_vld <= 1'b1;
      end
    end
  end

endmodule
